rv523_serial_alu: RTL and testbench

//  Digit-serial integer ALU for the RV523 execute stage; consumes the gate-cell library as its datapath
//  (one full-adder slice of NAND2/AOI21/OAI21/NOT cells, reused every cycle). Trades latency for transistor

---
 rtl/rv523_alu_pkg.sv | 69 ++++++
 rtl/rv523_fa_slice.sv | 49 ++++
 rtl/rv523_serial_alu.sv | 190 +++++++++++++++++++
 tb/tb_rv523_serial_alu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv523_alu_pkg.sv
// ----------------------------------------------------------------------------
// rv523_alu_pkg
// Shared types and helpers for the RV523 digit-serial ALU.
//   alu_op_t    : 4-bit operation code seen on the ALU op port
//   alu_state_t : control FSM states (IDLE / RUN / DONE)
//   nand2/aoi21/oai21/not1 : behavioural models of the gate-cell library,
//                            used to build the adder slice cell by cell
//   is_sub_op / is_shift_op : op-class decoders shared by the datapath
// No ports (package).
// ----------------------------------------------------------------------------
package rv523_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [3:0] {
        ADD  = OP_ADD,
        SUB  = OP_SUB,
        AND  = OP_AND,
        OR   = OP_OR,
        XOR  = OP_XOR,
        SLT  = OP_SLT,
        SLTU = OP_SLTU,
        SLL  = OP_SLL,
        SRL  = OP_SRL,
        SRA  = OP_SRA
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Gate-cell library models
    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    function automatic logic aoi21(input logic x0, input logic x1, input logic y);
        return ~((x0 & x1) | y);
    endfunction

    function automatic logic oai21(input logic x0, input logic x1, input logic y);
        return ~((x0 | x1) & y);
    endfunction

    function automatic logic not1(input logic x);
        return ~x;
    endfunction

    // Ops that compute A + ~B + 1 on the carry chain
    function automatic logic is_sub_op(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/rv523_fa_slice.sv
// ----------------------------------------------------------------------------
// rv523_fa_slice
// DIGIT-bit ripple-carry full adder assembled only from library cells
// (NAND2, AOI21, NOT). Purely combinational; the top reuses it every cycle.
// Ports:
//   a_d  [DIGIT-1:0] in   operand A digit
//   b_d  [DIGIT-1:0] in   operand B digit (already inverted for subtraction)
//   cin              in   carry into bit 0
//   s_d  [DIGIT-1:0] out  sum digit
//   cout             out  carry out of the top bit
// ----------------------------------------------------------------------------
module rv523_fa_slice
    import rv523_alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : gen_bit
        logic n_ab, p_l, p_r, p, n_pc, q_l, q_r, g;

        // Four-NAND XOR for propagate, then again for the sum
        assign n_ab = nand2(a_d[i], b_d[i]);
        assign p_l  = nand2(a_d[i], n_ab);
        assign p_r  = nand2(b_d[i], n_ab);
        assign p    = nand2(p_l, p_r);

        assign n_pc = nand2(p, c[i]);
        assign q_l  = nand2(p, n_pc);
        assign q_r  = nand2(c[i], n_pc);
        assign s_d[i] = nand2(q_l, q_r);

        // carry = g | (p & cin), formed as NOT(AOI21(p, cin, g))
        assign g        = not1(n_ab);
        assign c[i + 1] = not1(aoi21(p, c[i], g));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/rv523_serial_alu.sv
// ----------------------------------------------------------------------------
// rv523_serial_alu
// Digit-serial integer ALU for the RV523 execute stage. Operands are captured
// into shift registers and consumed LSB-first, DIGIT bits per cycle, through a
// single rv523_fa_slice and one carry flop. Result is held until writeback
// takes it.
// Optional feature macro: RV523_SERIAL_SHIFT_EN enables SLL/SRL/SRA
// (1 bit per cycle, latency max(1, b[4:0])). Without it those codes behave
// as undefined ops (full latency, result 0).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands/op presented
//   in_ready   out  ALU idle, op accepted this cycle
//   op   [3:0] in   alu_op_t code
//   a    [XLEN-1:0] in  operand A
//   b    [XLEN-1:0] in  operand B; b[4:0] is the shift amount
//   res_valid  out  result available, held until taken
//   res_ready  in   writeback accepts result
//   result [XLEN-1:0] out result, stable while res_valid
// ----------------------------------------------------------------------------
module rv523_serial_alu
    import rv523_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result
);

    localparam int NDIG       = XLEN / DIGIT;
    localparam int CNT_W_BASE = $clog2(NDIG) + 1;
`ifdef RV523_SERIAL_SHIFT_EN
    // Shift ops count up to 31 single-bit steps regardless of DIGIT
    localparam int CNT_W      = (CNT_W_BASE > 5) ? CNT_W_BASE : 5;
`else
    localparam int CNT_W      = CNT_W_BASE;
`endif

    alu_state_t       state, next_state;
    logic [XLEN-1:0]  a_sr, b_sr, result_r, res_next;
    logic [3:0]       op_r;
    logic             a_msb, b_msb, carry;
    logic [CNT_W-1:0] count, count_load;
    logic             transfer, last;
    logic [DIGIT-1:0] a_digit, b_digit, sum_d, digit_out;
    logic             cout, slt_bit, sltu_bit;
`ifdef RV523_SERIAL_SHIFT_EN
    logic             shamt_zero;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last)     next_state = DONE;
            DONE:    if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        res_valid = (state == DONE);
    end

    assign transfer = in_valid & in_ready;
    assign last     = (state == RUN) && (count == CNT_W'(1));
    assign result   = result_r;

    // ------------------------------------------------------------------
    // Datapath: one adder slice reused every RUN cycle
    // ------------------------------------------------------------------
    assign a_digit = a_sr[DIGIT-1:0];

    always_comb begin
        b_digit = b_sr[DIGIT-1:0];
        if (is_sub_op(op_r)) b_digit = ~b_digit;
    end

    rv523_fa_slice #(.DIGIT(DIGIT)) u_fa_slice (
        .a_d  (a_digit),
        .b_d  (b_digit),
        .cin  (carry),
        .s_d  (sum_d),
        .cout (cout)
    );

    // Logic ops bypass the carry chain but keep the same digit cadence
    always_comb begin
        digit_out = '0;
        case (op_r)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU: digit_out = sum_d;
            OP_AND:  digit_out = a_digit & b_sr[DIGIT-1:0];
            OP_OR:   digit_out = a_digit | b_sr[DIGIT-1:0];
            OP_XOR:  digit_out = a_digit ^ b_sr[DIGIT-1:0];
            default: digit_out = '0;
        endcase
    end

    // Signs differ -> A's sign decides; otherwise the difference sign does
    assign slt_bit  = (a_msb != b_msb) ? a_msb : sum_d[DIGIT-1];
    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned
    assign sltu_bit = ~cout;

    always_comb begin
        res_next = {digit_out, result_r[XLEN-1:DIGIT]};
        if (last && (op_r == OP_SLT))  res_next = {{(XLEN-1){1'b0}}, slt_bit};
        if (last && (op_r == OP_SLTU)) res_next = {{(XLEN-1){1'b0}}, sltu_bit};
`ifdef RV523_SERIAL_SHIFT_EN
        if (is_shift_op(op_r)) begin
            if (shamt_zero) begin
                res_next = result_r;
            end else begin
                case (op_r)
                    OP_SLL:  res_next = {result_r[XLEN-2:0], 1'b0};
                    OP_SRL:  res_next = {1'b0, result_r[XLEN-1:1]};
                    default: res_next = {a_msb, result_r[XLEN-1:1]};
                endcase
            end
        end
`endif
    end

    always_comb begin
        count_load = CNT_W'(NDIG);
`ifdef RV523_SERIAL_SHIFT_EN
        if (is_shift_op(op)) begin
            count_load = (b[4:0] == 5'd0) ? CNT_W'(1) : CNT_W'(b[4:0]);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            result_r <= '0;
            op_r     <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            carry    <= 1'b0;
            count    <= '0;
`ifdef RV523_SERIAL_SHIFT_EN
            shamt_zero <= 1'b0;
`endif
        end else if (transfer) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            a_msb <= a[XLEN-1];
            b_msb <= b[XLEN-1];
            carry <= is_sub_op(op);
            count <= count_load;
`ifdef RV523_SERIAL_SHIFT_EN
            shamt_zero <= (b[4:0] == 5'd0);
            // Shifts work in place on the result register, seeded with A
            if (is_shift_op(op)) result_r <= a;
`endif
        end else if (state == RUN) begin
            a_sr     <= a_sr >> DIGIT;
            b_sr     <= b_sr >> DIGIT;
            carry    <= cout;
            count    <= count - CNT_W'(1);
            result_r <= res_next;
        end
    end

endmodule

// File: tb/tb_rv523_serial_alu.sv
// ----------------------------------------------------------------------------
// tb_rv523_serial_alu
// Self-checking bench: directed corner cases, a DONE-stall, an asynchronous
// reset in mid-RUN, then randomised ops with random writeback back-pressure.
// Expected results come from an arithmetic reference model and are queued at
// issue time; an independent monitor pops them when res_valid rises.
// ----------------------------------------------------------------------------
module tb_rv523_serial_alu;
    import rv523_alu_pkg::*;

    localparam int XLEN   = 32;
    localparam int DIGIT  = 4;
    localparam int NDIG   = XLEN / DIGIT;
    localparam int BUDGET = 200;
    localparam int N_RAND = 1000;

    logic            clk, rst, in_valid, in_ready, res_valid, res_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b, result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   rr_mode  = 2;   // 0 random, 1 hold low, 2 hold high
    bit   abort    = 0;

    rv523_serial_alu #(.XLEN(XLEN), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on whole words
    function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
`ifdef RV523_SERIAL_SHIFT_EN
            OP_SLL:  return x << y[4:0];
            OP_SRL:  return x >> y[4:0];
            OP_SRA:  return 32'($signed(x) >>> y[4:0]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] o, input logic [31:0] y);
`ifdef RV523_SERIAL_SHIFT_EN
        if (o == OP_SLL || o == OP_SRL || o == OP_SRA)
            return (y[4:0] == 5'd0) ? 1 : int'(y[4:0]);
`endif
        return NDIG;
    endfunction

    // Present one op, wait (bounded) for acceptance, queue its expectation
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int w = 0;
        if (abort) return;
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        while (!in_ready && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("issue_accept", {31'd0, in_ready}, 32'd1);
            abort = 1;
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{res: ref_result(o, x, y), lat: ref_latency(o, y), t: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        if (abort) return;
        while ((sb.size() != 0 || !in_ready || res_valid) && w < BUDGET) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", sb.size(), 32'd0);
        if (sb.size() != 0) abort = 1;
    endtask

    // Writeback back-pressure
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       res_ready = 1'b0;
                2:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pop on each new result, then check it stays put until taken
    initial begin : monitor
        logic            seen;
        logic [XLEN-1:0] held;
        exp_t            e;
        seen = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst || !res_valid) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_result got %h want none (cycle %0d)", result, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("result", result, e.res);
                        check("latency", cyc - e.t, e.lat);
                    end
                    held = result;
                    seen = 1'b1;
                end else begin
                    check("result_hold", result, held);
                end
                if (res_ready) seen = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int w;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        // Directed corner cases
        issue(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001);
        issue(OP_SUB,  32'd5,         32'd7);
        issue(OP_SLT,  32'h8000_0000, 32'd1);
        issue(OP_SLTU, 32'h8000_0000, 32'd1);
        issue(OP_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF);
        issue(OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00);
        issue(OP_OR,   32'hF0F0_1234, 32'h0FF0_FF00);
        issue(OP_XOR,  32'hF0F0_1234, 32'h0FF0_FF00);
        issue(4'd12,   32'hDEAD_BEEF, 32'h1234_5678);
        issue(OP_SLL,  32'h0000_0001, 32'h0000_0003);
`ifdef RV523_SERIAL_SHIFT_EN
        issue(OP_SRA,  32'h8000_0010, 32'd4);
        issue(OP_SLL,  32'hDEAD_BEEF, 32'h0000_0020);
`endif
        wait_idle();

        // Hold the result in DONE while new requests knock on the door
        rr_mode = 1;
        issue(OP_ADD, 32'h1234_5678, 32'h1111_1111);
        w = 0;
        while (!res_valid && w < BUDGET && !abort) begin
            @(negedge clk);
            w++;
        end
        check("stall_reach_done", {31'd0, res_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_res_valid", {31'd0, res_valid}, 32'd1);
            check("stall_result", result, 32'h2345_6789);
            op = OP_XOR;
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rr_mode = 2;
        wait_idle();

        // Asynchronous reset in the middle of RUN
        issue(OP_ADD, 32'h0F0F_0F0F, 32'h0000_0001);
        repeat (NDIG / 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrun_rst_result", result, 32'd0);
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        issue(OP_ADD, 32'd3, 32'd4);
        wait_idle();

        // Randomised ops with random back-pressure
        rr_mode = 0;
        for (int i = 0; i < N_RAND && !abort; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y;
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0:       y = x;
                1:       y[4:0] = 5'd0;
                2:       x = 32'h8000_0000;
                3:       y = 32'hFFFF_FFFF;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(o, x, y);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
